// File: rtl/framebuffer_fill_ctrl.sv
// Rectangle fill engine for a W x H framebuffer with a user write pass-through while idle.
// Optional abort input/aborted output are compiled in with the FB_FILL_ABORT_EN macro.
module framebuffer_fill_ctrl #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8,
  parameter int COORD_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y1,
  input  logic [DATA_WIDTH-1:0]  color,
`ifdef FB_FILL_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   usr_en_wr,
  input  logic [ADDR_WIDTH-1:0]  usr_addr_wr,
  input  logic [DATA_WIDTH-1:0]  usr_din,
  output logic                   usr_ready,
  output logic                   fb_en_wr,
  output logic                   fb_wrea,
  output logic [ADDR_WIDTH-1:0]  fb_addr_wr,
  output logic [DATA_WIDTH-1:0]  fb_din
);

  localparam int W = FRAME_WIDTH / SCALING_FACTOR;
  localparam int H = FRAME_HEIGHT / SCALING_FACTOR;
  localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [COORD_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [DATA_WIDTH-1:0]  color_q, color_d;
  logic                   err_q, err_d;
  logic                   abort_w;
  logic                   rect_ok;
  logic [ADDR_WIDTH-1:0]  start_base;

`ifdef FB_FILL_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_w = abort;
  assign aborted_d = (state_q == S_FILL) && abort;
  assign aborted = aborted_q && (state_q == S_DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end
`else
  assign abort_w = 1'b0;
`endif

  assign rect_ok = (x0 <= x1) && (y0 <= y1) && (32'(x1) < W) && (32'(y1) < H);
  // The only multiply: the starting row base, computed once per fill.
  assign start_base = ADDR_WIDTH'(32'(y0) * W);

  assign busy      = (state_q != S_IDLE);
  assign usr_ready = !busy;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign fb_wrea   = fb_en_wr;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    color_d    = color_q;
    err_d      = 1'b0;
    fb_en_wr   = 1'b0;
    fb_addr_wr = base_q + ADDR_WIDTH'(x_q);
    fb_din     = color_q;
    case (state_q)
      S_IDLE: begin
        fb_en_wr   = usr_en_wr;
        fb_addr_wr = usr_addr_wr;
        fb_din     = usr_din;
        if (start) begin
          if (rect_ok) begin
            state_d = S_FILL;
            x0_d    = x0;
            x1_d    = x1;
            y1_d    = y1;
            x_d     = x0;
            y_d     = y0;
            base_d  = start_base;
            color_d = color;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (abort_w) begin
          state_d = S_DONE;
        end else begin
          fb_en_wr = 1'b1;
          if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              state_d = S_DONE;
            end else begin
              x_d    = x0_q;
              y_d    = y_q + 1'b1;
              base_d = base_q + W_A;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      color_q <= color_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_fill_ctrl.sv
// Randomized bench for framebuffer_fill_ctrl: a per-cycle expectation derived from raster
// loops over the requested rectangle, checked on every falling edge.
module tb_framebuffer_fill_ctrl;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  x0, y0, x1, y1;
  logic [7:0]  color;
  logic        busy, done, err;
  logic        usr_en_wr;
  logic [18:0] usr_addr_wr;
  logic [7:0]  usr_din;
  logic        usr_ready;
  logic        fb_en_wr, fb_wrea;
  logic [18:0] fb_addr_wr;
  logic [7:0]  fb_din;
`ifdef FB_FILL_ABORT_EN
  logic abort, aborted;
`endif

  always #5 clk = ~clk;

  framebuffer_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
`ifdef FB_FILL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .err(err),
    .usr_en_wr(usr_en_wr), .usr_addr_wr(usr_addr_wr), .usr_din(usr_din), .usr_ready(usr_ready),
    .fb_en_wr(fb_en_wr), .fb_wrea(fb_wrea), .fb_addr_wr(fb_addr_wr), .fb_din(fb_din)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit pend_err = 1'b0;
  logic        e_en, e_busy, e_done, e_err, e_ab;
  logic [18:0] e_addr;
  logic [7:0]  e_din;
  logic [18:0] cap_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("fb_en_wr", 32'(fb_en_wr), 32'(e_en));
      chk("fb_wrea", 32'(fb_wrea), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("usr_ready", 32'(usr_ready), 32'(!e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (e_en || !e_busy) begin
        chk("fb_addr_wr", 32'(fb_addr_wr), 32'(e_addr));
        chk("fb_din", 32'(fb_din), 32'(e_din));
      end
`ifdef FB_FILL_ABORT_EN
      chk("aborted", 32'(aborted), 32'(e_ab));
`endif
      if (fb_en_wr && busy) cap_q.push_back(fb_addr_wr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle: user port passes straight through; err reflects the previous cycle's start.
  task automatic idle_cyc(input bit st, input bit bad);
    usr_en_wr   = 1'($urandom);
    usr_addr_wr = 19'($urandom);
    usr_din     = 8'($urandom);
    start       = st;
    e_en = usr_en_wr; e_addr = usr_addr_wr; e_din = usr_din;
    e_busy = 1'b0; e_done = 1'b0; e_err = pend_err; e_ab = 1'b0;
    pend_err = st && bad;
    chk_on = 1'b1;
    tick();
  endtask

  // Busy cycle: user writes held high and start/coords scrambled, none of which may leak out.
  task automatic busy_cyc(input bit we, input logic [18:0] a, input logic [7:0] d,
                          input bit dn, input bit ab);
    usr_en_wr   = 1'b1;
    usr_addr_wr = 19'($urandom);
    usr_din     = 8'($urandom);
    start       = 1'($urandom);
    x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom); y1 = 10'($urandom);
    color = 8'($urandom);
    e_en = we; e_addr = a; e_din = d;
    e_busy = 1'b1; e_done = dn; e_err = 1'b0; e_ab = ab;
    tick();
  endtask

  task automatic fill(input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [7:0] col, input int cut);
    bit ok;
    int n;
    ok = (ax0 <= ax1) && (ay0 <= ay1) && (ax1 < W) && (ay1 < H);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1); color = col;
    idle_cyc(1'b1, !ok);
    if (!ok) return;
    n = 0;
    for (int y = ay0; y <= ay1; y++) begin
      for (int x = ax0; x <= ax1; x++) begin
        if (n == cut) return;
        busy_cyc(1'b1, 19'(y * W + x), col, 1'b0, 1'b0);
        n++;
      end
    end
    busy_cyc(1'b0, 19'd0, col, 1'b1, 1'b0);
  endtask

  initial begin
    int lit[6];
    int bad;
    int ax0, ay0, ax1, ay1;
    lit = '{1290, 1291, 1292, 1930, 1931, 1932};
    rst_n = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    usr_en_wr = 1'b0; usr_addr_wr = '0; usr_din = '0;
`ifdef FB_FILL_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    idle_cyc(1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cyc(1'b0, 1'b0);

    cap_q.delete();
    fill(10, 2, 12, 3, 8'hA5, -1);
    idle_cyc(1'b0, 1'b0);
    chk("n_writes_small", 32'(cap_q.size()), 32'd6);
    for (int i = 0; i < cap_q.size() && i < 6; i++) chk("addr_small", 32'(cap_q[i]), 32'(lit[i]));

    cap_q.delete();
    fill(5, 5, 4, 5, 8'h11, -1);
    idle_cyc(1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    chk("n_writes_err", 32'(cap_q.size()), 32'd0);

    cap_q.delete();
    fill(0, 0, W - 1, 9, 8'h00, -1);
    idle_cyc(1'b0, 1'b0);
    chk("n_writes_band", 32'(cap_q.size()), 32'd6400);
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i] != 19'(i)) bad++;
    chk("band_consecutive", 32'(bad), 32'd0);

    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        ax0 = $urandom_range(630, 639); ay0 = $urandom_range(470, 479);
      end else begin
        ax0 = $urandom_range(0, 639); ay0 = $urandom_range(0, 479);
      end
      ax1 = ax0 + int'($urandom_range(0, 9)) - 2;
      ay1 = ay0 + int'($urandom_range(0, 6)) - 1;
      if (ax1 < 0) ax1 = 0;
      if (ay1 < 0) ay1 = 0;
      fill(ax0, ay0, ax1, ay1, 8'($urandom), -1);
      repeat ($urandom_range(0, 2)) idle_cyc(1'b0, 1'b0);
    end
    idle_cyc(1'b0, 1'b0);

    fill(0, 0, W - 1, H - 1, 8'h3C, 100);
    rst_n = 1'b0;
    pend_err = 1'b0;
    idle_cyc(1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cyc(1'b0, 1'b0);
    cap_q.delete();
    fill(0, 0, 0, 0, 8'h77, -1);
    idle_cyc(1'b0, 1'b0);
    chk("n_writes_pixel", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() > 0) chk("addr_pixel", 32'(cap_q[0]), 32'd0);

`ifdef FB_FILL_ABORT_EN
    cap_q.delete();
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd0; color = 8'h5A;
    idle_cyc(1'b1, 1'b0);
    busy_cyc(1'b1, 19'd0, 8'h5A, 1'b0, 1'b0);
    busy_cyc(1'b1, 19'd1, 8'h5A, 1'b0, 1'b0);
    abort = 1'b1;
    busy_cyc(1'b0, 19'd0, 8'h5A, 1'b0, 1'b0);
    abort = 1'b0;
    busy_cyc(1'b0, 19'd0, 8'h5A, 1'b1, 1'b1);
    idle_cyc(1'b0, 1'b0);
    chk("n_writes_abort", 32'(cap_q.size()), 32'd2);
`endif

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_fill_ctrl.md
FRAMEBUFFER_FILL_CTRL -- requirements
Module: framebuffer_fill_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, full-resolution frame width in pixels.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, full-resolution frame height in pixels.
REQ-003 SHALL have parameter SCALING_FACTOR, default 1, divisor giving stored W = FRAME_WIDTH/SCALING_FACTOR and H = FRAME_HEIGHT/SCALING_FACTOR.
REQ-004 SHALL have parameter ADDR_WIDTH, default 19, framebuffer address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-006 SHALL have parameter COORD_WIDTH, default 10, width of each rectangle coordinate.
REQ-007 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  request a rectangle fill; x0, y0, x1, y1  in  COORD_WIDTH each  inclusive corners; color  in  DATA_WIDTH  fill value.
REQ-010 busy  out  1  fill in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle invalid-rectangle pulse.
REQ-011 usr_en_wr  in  1, usr_addr_wr  in  ADDR_WIDTH, usr_din  in  DATA_WIDTH: user write port; usr_ready  out  1: user write accepted.
REQ-012 fb_en_wr, fb_wrea  out  1; fb_addr_wr  out  ADDR_WIDTH; fb_din  out  DATA_WIDTH: framebuffer write port.

Function
REQ-013 SHALL implement states IDLE, FILL, DONE; busy = (state != IDLE); usr_ready = !busy.
REQ-014 In IDLE, fb_en_wr = fb_wrea = usr_en_wr, fb_addr_wr = usr_addr_wr, fb_din = usr_din, combinationally.
REQ-015 start SHALL be sampled only in IDLE; start in FILL or DONE is ignored.
REQ-016 On start, if x0>x1, y0>y1, x1>=W or y1>=H: err pulses next cycle, state stays IDLE, no fill writes.
REQ-017 On valid start: latch coordinates and color, enter FILL next cycle; first fill write occurs that cycle.
REQ-018 In FILL: exactly one write per cycle (fb_en_wr = fb_wrea = 1, fb_din = latched color), raster order, x0..x1 within row, rows y0..y1.
REQ-019 Address SHALL be y*W + x, computed incrementally (row base += W on row wrap); no multiplier in the per-pixel path.
REQ-020 Total writes SHALL equal (x1-x0+1)*(y1-y0+1); after write of (x1,y1), enter DONE.
REQ-021 DONE lasts one cycle: done = 1, no write, then IDLE.
REQ-022 During FILL and DONE, usr_en_wr SHALL be ignored and not forwarded.
REQ-023 start and usr_en_wr in the same IDLE cycle: user write forwarded that cycle, fill begins next.
REQ-024 Single-pixel rectangle: one write, done asserted 2 cycles after the start cycle.

Reset
REQ-025 While rst_n = 0: state IDLE, busy/done/err = 0, latched registers 0; fb_* follow REQ-014 pass-through.
REQ-026 Reset asserted mid-fill SHALL abandon the fill immediately, with no done pulse.

Configuration
REQ-027 Macro FB_FILL_ABORT_EN: when defined, add input abort (1) and output aborted (1); abort high in FILL suppresses that cycle's write and enters DONE, with aborted = 1 alongside done.
REQ-028 Without FB_FILL_ABORT_EN: abort and aborted ports are absent, and every valid fill runs to completion.

Verification
REQ-029 W=640,H=480: start (0,0)-(639,479), color 0x00 -> 307200 writes, addresses 0..307199 consecutive, then done.
REQ-030 Start (10,2)-(12,3), color 0xA5 -> addresses 1290,1291,1292,1930,1931,1932 all 0xA5, done the cycle after the last write.
REQ-031 Start (5,5)-(4,5) -> err pulse, no fb write, busy stays 0.
REQ-032 usr_en_wr held high during a fill -> no user address appears on fb_addr_wr, usr_ready = 0 until IDLE.
REQ-033 rst_n low after 100 fill writes -> busy = 0 immediately, no done; a following start (0,0)-(0,0) writes address 0 once.
REQ-034 With FB_FILL_ABORT_EN: abort on the 3rd fill cycle -> exactly 2 writes, done = aborted = 1 on the next cycle.
